// File: rtl/top_memory.sv
// Memory stage of the pipelined RISC-V core.
// Holds the EX/MEM register and runs byte/halfword/word loads and stores over a
// req/ack data-memory port. Upstream stages stall while an access is outstanding.
// The aligned, extended result is handed to writeback through the MEM/WB register.
module top_memory #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic                      clk,
    input  logic                      rst_n,
    // execute-stage slot
    input  logic                      valid_E,
    input  logic [DATA_WIDTH-1:0]     ALUout_E,
    input  logic [DATA_WIDTH-1:0]     writeData_E,
    input  logic                      memRead_E,
    input  logic                      memWrite_E,
    input  logic [2:0]                funct3_E,
    input  logic                      regWrite_E,
    input  logic [REG_ADDR_WIDTH-1:0] rd_E,
    input  logic                      flush_M,
    // hazard unit
    output logic                      stall_M,
    // data-memory port
    output logic                      mem_req,
    output logic                      mem_we,
    output logic [DATA_WIDTH-1:0]     mem_addr,
    output logic [DATA_WIDTH-1:0]     mem_wdata,
    output logic [3:0]                mem_wstrb,
    input  logic [DATA_WIDTH-1:0]     mem_rdata,
    input  logic                      mem_ack,
    // writeback slot
    output logic                      valid_W,
    output logic                      regWrite_W,
    output logic [REG_ADDR_WIDTH-1:0] rd_W,
    output logic [DATA_WIDTH-1:0]     result_W,
    output logic                      misalign_W
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

    // EX/MEM register
    logic                      r_m_valid;
    logic [DATA_WIDTH-1:0]     r_m_addr;
    logic [DATA_WIDTH-1:0]     r_m_wdata;
    logic [REG_ADDR_WIDTH-1:0] r_m_rd;
    logic                      r_m_read;
    logic                      r_m_write;
    logic                      r_m_regwrite;
    logic [2:0]                r_m_funct3;

    state_t                    r_state;

    logic                      w_mop;
    logic                      w_misalign;
    logic                      w_access;
    logic                      w_mem_req;
    logic [3:0]                w_wstrb;
    logic [DATA_WIDTH-1:0]     w_wdata;
    logic [7:0]                w_byte;
    logic [15:0]               w_half;
    logic [DATA_WIDTH-1:0]     w_load_data;

    assign w_mop = r_m_valid & (r_m_read | r_m_write);

    // Alignment check: halfwords need addr[0]=0, words need addr[1:0]=00.
    always_comb begin
        // NOTE: default first so every path assigns the signal and no latch is inferred.
        w_misalign = 1'b0;
        if (w_mop) begin
            case (r_m_funct3[1:0])
                2'b01:   w_misalign = r_m_addr[0];
                2'b10:   w_misalign = (r_m_addr[1:0] != 2'b00);
                default: w_misalign = 1'b0;
            endcase
        end
    end

    // A request is presented for every aligned memory op; BUSY keeps it up until ack.
    assign w_access  = w_mop & ~w_misalign;
    assign w_mem_req = w_access | (r_state == S_BUSY);
    assign stall_M   = w_mem_req & ~mem_ack;

    // Store lane replication and byte enables from size and low address bits.
    always_comb begin
        w_wdata = r_m_wdata;
        w_wstrb = 4'b1111;
        case (r_m_funct3[1:0])
            2'b00: begin
                w_wdata = {4{r_m_wdata[7:0]}};
                w_wstrb = 4'b0001 << r_m_addr[1:0];
            end
            2'b01: begin
                w_wdata = {2{r_m_wdata[15:0]}};
                w_wstrb = 4'b0011 << r_m_addr[1:0];
            end
            default: begin
                w_wdata = r_m_wdata;
                w_wstrb = 4'b1111;
            end
        endcase
    end

    assign mem_req   = w_mem_req;
    assign mem_we    = w_mem_req & r_m_write;
    assign mem_addr  = {r_m_addr[DATA_WIDTH-1:2], 2'b00};
    assign mem_wdata = w_wdata;
    assign mem_wstrb = (w_mem_req & r_m_write) ? w_wstrb : 4'b0000;

    // Load lane selection and sign/zero extension of the ack-cycle read data.
    always_comb begin
        case (r_m_addr[1:0])
            2'b00:   w_byte = mem_rdata[7:0];
            2'b01:   w_byte = mem_rdata[15:8];
            2'b10:   w_byte = mem_rdata[23:16];
            default: w_byte = mem_rdata[31:24];
        endcase
        w_half = r_m_addr[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (r_m_funct3)
            3'b000:  w_load_data = {{24{w_byte[7]}}, w_byte};
            3'b001:  w_load_data = {{16{w_half[15]}}, w_half};
            3'b100:  w_load_data = {24'h000000, w_byte};
            3'b101:  w_load_data = {16'h0000, w_half};
            default: w_load_data = mem_rdata;
        endcase
    end

    // EX/MEM register: holds while stalled, captures a bubble on flush.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (!rst_n) begin
            r_m_valid    <= 1'b0;
            r_m_addr     <= '0;
            r_m_wdata    <= '0;
            r_m_rd       <= '0;
            r_m_read     <= 1'b0;
            r_m_write    <= 1'b0;
            r_m_regwrite <= 1'b0;
            r_m_funct3   <= 3'b000;
        end else if (!stall_M) begin
            r_m_valid    <= valid_E & ~flush_M;
            r_m_addr     <= ALUout_E;
            r_m_wdata    <= writeData_E;
            r_m_rd       <= rd_E;
            r_m_read     <= memRead_E;
            r_m_write    <= memWrite_E;
            r_m_regwrite <= regWrite_E;
            r_m_funct3   <= funct3_E;
        end
    end

    // Access FSM and MEM/WB register; W loads whenever the stage is not stalled.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            valid_W    <= 1'b0;
            regWrite_W <= 1'b0;
            rd_W       <= '0;
            result_W   <= '0;
            misalign_W <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE:  if (w_access && !mem_ack) r_state <= S_BUSY;
                S_BUSY:  if (mem_ack) r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase

            if (stall_M) begin
                // The stalled instruction is not done yet: W carries a bubble meanwhile.
                valid_W    <= 1'b0;
                regWrite_W <= 1'b0;
                misalign_W <= 1'b0;
            end else begin
                valid_W    <= r_m_valid;
                regWrite_W <= r_m_valid & r_m_regwrite & ~r_m_write & ~w_misalign;
                rd_W       <= r_m_rd;
                misalign_W <= w_misalign;
                if (w_misalign)
                    result_W <= '0;
                else if (w_mop && r_m_read)
                    result_W <= w_load_data;
                else
                    result_W <= r_m_addr;
            end
        end
    end

endmodule

// File: tb/tb_top_memory.sv
// Directed bench for the memory stage: lanes, wait states, misalignment,
// flush/stall interaction and reset in the middle of an access.
module tb_top_memory;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid_E;
    logic [31:0] ALUout_E;
    logic [31:0] writeData_E;
    logic        memRead_E;
    logic        memWrite_E;
    logic [2:0]  funct3_E;
    logic        regWrite_E;
    logic [4:0]  rd_E;
    logic        flush_M;
    logic        stall_M;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic        valid_W;
    logic        regWrite_W;
    logic [4:0]  rd_W;
    logic [31:0] result_W;
    logic        misalign_W;

    int n_vec = 0;
    int n_err = 0;

    // values seen during the M cycle of run_op
    logic        obs_req;
    logic        obs_stall;
    logic        obs_we;
    logic [3:0]  obs_wstrb;
    logic [31:0] obs_wdata;
    logic [31:0] obs_addr;

    top_memory #(.DATA_WIDTH(32), .REG_ADDR_WIDTH(5)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .valid_E     (valid_E),
        .ALUout_E    (ALUout_E),
        .writeData_E (writeData_E),
        .memRead_E   (memRead_E),
        .memWrite_E  (memWrite_E),
        .funct3_E    (funct3_E),
        .regWrite_E  (regWrite_E),
        .rd_E        (rd_E),
        .flush_M     (flush_M),
        .stall_M     (stall_M),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_wstrb   (mem_wstrb),
        .mem_rdata   (mem_rdata),
        .mem_ack     (mem_ack),
        .valid_W     (valid_W),
        .regWrite_W  (regWrite_W),
        .rd_W        (rd_W),
        .result_W    (result_W),
        .misalign_W  (misalign_W)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no end of test, expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_e(input logic rd_op, input logic wr_op, input logic rw,
                           input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wd, input logic [4:0] rd);
        valid_E     = 1'b1;
        memRead_E   = rd_op;
        memWrite_E  = wr_op;
        regWrite_E  = rw;
        funct3_E    = f3;
        ALUout_E    = addr;
        writeData_E = wd;
        rd_E        = rd;
    endtask

    task automatic idle_e();
        valid_E    = 1'b0;
        memRead_E  = 1'b0;
        memWrite_E = 1'b0;
        regWrite_E = 1'b0;
    endtask

    // One instruction through M; memory answers (or not) in its first M cycle.
    task automatic run_op(input logic rd_op, input logic wr_op, input logic rw,
                          input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wd, input logic [4:0] rd,
                          input logic ack, input logic [31:0] rdata);
        drive_e(rd_op, wr_op, rw, f3, addr, wd, rd);
        tick();
        idle_e();
        mem_ack   = ack;
        mem_rdata = rdata;
        #1;
        obs_req   = mem_req;
        obs_stall = stall_M;
        obs_we    = mem_we;
        obs_wstrb = mem_wstrb;
        obs_wdata = mem_wdata;
        obs_addr  = mem_addr;
        tick();
        mem_ack = 1'b0;
    endtask

    initial begin
        rst_n       = 1'b0;
        flush_M     = 1'b0;
        mem_ack     = 1'b0;
        mem_rdata   = 32'h0;
        ALUout_E    = 32'h0;
        writeData_E = 32'h0;
        funct3_E    = 3'b000;
        rd_E        = 5'd0;
        idle_e();
        tick();
        tick();

        // reset state
        check("rst_mem_req",    mem_req,    0);
        check("rst_stall",      stall_M,    0);
        check("rst_mem_we",     mem_we,     0);
        check("rst_mem_wstrb",  mem_wstrb,  0);
        check("rst_mem_addr",   mem_addr,   0);
        check("rst_mem_wdata",  mem_wdata,  0);
        check("rst_valid_W",    valid_W,    0);
        check("rst_regWrite_W", regWrite_W, 0);
        check("rst_rd_W",       rd_W,       0);
        check("rst_result_W",   result_W,   0);
        check("rst_misalign_W", misalign_W, 0);
        rst_n = 1'b1;
        tick();

        // store then load, both acked in the same cycle
        run_op(1'b0, 1'b1, 1'b0, 3'b010, 32'h100, 32'hDEADBEEF, 5'd0, 1'b1, 32'h0);
        check("sw_req",        obs_req,    1);
        check("sw_we",         obs_we,     1);
        check("sw_wstrb",      obs_wstrb,  4'b1111);
        check("sw_wdata",      obs_wdata,  32'hDEADBEEF);
        check("sw_addr",       obs_addr,   32'h100);
        check("sw_stall",      obs_stall,  0);
        check("sw_valid_W",    valid_W,    1);
        check("sw_regWrite_W", regWrite_W, 0);
        run_op(1'b1, 1'b0, 1'b1, 3'b010, 32'h100, 32'h0, 5'd5, 1'b1, 32'hDEADBEEF);
        check("lw_stall",      obs_stall,  0);
        check("lw_we",         obs_we,     0);
        check("lw_result",     result_W,   32'hDEADBEEF);
        check("lw_rd",         rd_W,       5);
        check("lw_regWrite_W", regWrite_W, 1);
        check("lw_valid_W",    valid_W,    1);

        // byte and halfword lanes on word 0x80FF7F01
        run_op(1'b1, 1'b0, 1'b1, 3'b000, 32'h103, 32'h0, 5'd1, 1'b1, 32'h80FF7F01);
        check("lb_addr",   obs_addr, 32'h100);
        check("lb_result", result_W, 32'hFFFFFF80);
        run_op(1'b1, 1'b0, 1'b1, 3'b100, 32'h103, 32'h0, 5'd1, 1'b1, 32'h80FF7F01);
        check("lbu_result", result_W, 32'h00000080);
        run_op(1'b1, 1'b0, 1'b1, 3'b001, 32'h102, 32'h0, 5'd1, 1'b1, 32'h80FF7F01);
        check("lh_result", result_W, 32'hFFFF80FF);
        run_op(1'b1, 1'b0, 1'b1, 3'b101, 32'h100, 32'h0, 5'd1, 1'b1, 32'h80FF7F01);
        check("lhu_result", result_W, 32'h00007F01);
        run_op(1'b0, 1'b1, 1'b0, 3'b000, 32'h101, 32'h123456AB, 5'd0, 1'b1, 32'h0);
        check("sb_wstrb", obs_wstrb, 4'b0010);
        check("sb_wdata", obs_wdata, 32'hABABABAB);
        check("sb_regWrite_W", regWrite_W, 0);
        run_op(1'b0, 1'b1, 1'b0, 3'b001, 32'h102, 32'h00001234, 5'd0, 1'b1, 32'h0);
        check("sh_wstrb", obs_wstrb, 4'b1100);
        check("sh_wdata", obs_wdata, 32'h12341234);

        // wait states: LW acked three cycles after the first request cycle
        drive_e(1'b1, 1'b0, 1'b1, 3'b010, 32'h200, 32'h0, 5'd7);
        tick();
        // a non-memory op waits in execute; it must not be captured during the stall
        drive_e(1'b0, 1'b0, 1'b1, 3'b000, 32'h55, 32'h0, 5'd9);
        for (int i = 0; i < 3; i++) begin
            #1;
            check($sformatf("ws_stall_%0d", i),   stall_M,  1);
            check($sformatf("ws_req_%0d", i),     mem_req,  1);
            check($sformatf("ws_addr_%0d", i),    mem_addr, 32'h200);
            tick();
            check($sformatf("ws_valid_W_%0d", i), valid_W,  0);
        end
        mem_ack   = 1'b1;
        mem_rdata = 32'hCAFEF00D;
        #1;
        check("ws_ack_stall", stall_M, 0);
        check("ws_ack_req",   mem_req, 1);
        tick();
        mem_ack = 1'b0;
        idle_e();
        check("ws_valid_W",  valid_W,  1);
        check("ws_result",   result_W, 32'hCAFEF00D);
        check("ws_rd",       rd_W,     7);
        tick();
        check("ws_next_valid_W", valid_W,  1);
        check("ws_next_result",  result_W, 32'h55);
        check("ws_next_rd",      rd_W,     9);
        tick();
        check("ws_pulse_end", valid_W, 0);

        // misaligned accesses: no request, one-cycle misalign pulse
        run_op(1'b1, 1'b0, 1'b1, 3'b010, 32'h102, 32'h0, 5'd6, 1'b0, 32'h0);
        check("mis_lw_req",        obs_req,    0);
        check("mis_lw_stall",      obs_stall,  0);
        check("mis_lw_misalign_W", misalign_W, 1);
        check("mis_lw_regWrite_W", regWrite_W, 0);
        check("mis_lw_valid_W",    valid_W,    1);
        check("mis_lw_result",     result_W,   0);
        run_op(1'b0, 1'b1, 1'b0, 3'b001, 32'h101, 32'h00001234, 5'd0, 1'b0, 32'h0);
        check("mis_sh_req",        obs_req,    0);
        check("mis_sh_stall",      obs_stall,  0);
        check("mis_sh_misalign_W", misalign_W, 1);
        check("mis_sh_regWrite_W", regWrite_W, 0);
        tick();
        check("mis_pulse_end", misalign_W, 0);

        // flush with a load in execute: bubble, no request
        drive_e(1'b1, 1'b0, 1'b1, 3'b010, 32'h100, 32'h0, 5'd2);
        flush_M = 1'b1;
        tick();
        flush_M = 1'b0;
        idle_e();
        #1;
        check("flush_req", mem_req, 0);
        tick();
        check("flush_valid_W", valid_W, 0);

        // flush during a stall is ignored; the stalled load completes
        drive_e(1'b1, 1'b0, 1'b1, 3'b010, 32'h300, 32'h0, 5'd3);
        tick();
        drive_e(1'b1, 1'b0, 1'b1, 3'b010, 32'h400, 32'h0, 5'd8);
        flush_M = 1'b1;
        #1;
        check("fs_stall", stall_M, 1);
        tick();
        check("fs_req",  mem_req,  1);
        check("fs_addr", mem_addr, 32'h300);
        mem_ack   = 1'b1;
        mem_rdata = 32'h11223344;
        tick();
        mem_ack = 1'b0;
        flush_M = 1'b0;
        idle_e();
        check("fs_valid_W", valid_W,  1);
        check("fs_result",  result_W, 32'h11223344);
        check("fs_rd",      rd_W,     3);
        #1;
        check("fs_bubble_req", mem_req, 0);
        tick();
        check("fs_bubble_valid_W", valid_W, 0);

        // reset while BUSY abandons the access; a late ack is ignored
        drive_e(1'b1, 1'b0, 1'b1, 3'b010, 32'h400, 32'h0, 5'd4);
        tick();
        idle_e();
        tick();
        check("rb_busy_stall", stall_M, 1);
        rst_n = 1'b0;
        tick();
        check("rb_req",        mem_req,    0);
        check("rb_stall",      stall_M,    0);
        check("rb_valid_W",    valid_W,    0);
        check("rb_regWrite_W", regWrite_W, 0);
        check("rb_rd_W",       rd_W,       0);
        check("rb_result_W",   result_W,   0);
        check("rb_misalign_W", misalign_W, 0);
        rst_n     = 1'b1;
        mem_ack   = 1'b1;
        mem_rdata = 32'hBAD0BAD0;
        #1;
        check("rb_late_req",   mem_req, 0);
        check("rb_late_stall", stall_M, 0);
        tick();
        mem_ack = 1'b0;
        check("rb_late_valid_W", valid_W, 0);
        tick();
        check("rb_idle_req", mem_req, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/top_memory.md
# top_memory

Memory stage of the pipelined RISC-V core. It sits directly downstream of the execute stage and holds the EX/MEM pipeline register. It performs byte, halfword and word loads and stores through a req/ack data-memory port that can take a variable number of cycles. It stalls the upstream stages while an access is outstanding, then hands an aligned, extended result to writeback through the MEM/WB register.

## Interface
Parameters:
- DATA_WIDTH, 32, datapath and address width (the block supports only 32).
- REG_ADDR_WIDTH, 5, destination register index width.

Ports:
- clk  in  1  rising-edge clock; the only clock.
- rst_n  in  1  synchronous, active-low reset, sampled on the rising edge of clk.
- valid_E  in  1  execute slot holds a real instruction.
- ALUout_E  in  DATA_WIDTH  ALU result; this is the byte address for loads and stores.
- writeData_E  in  DATA_WIDTH  store data (rs2).
- memRead_E, memWrite_E  in  1 each  load / store instruction.
- funct3_E  in  3  access size and sign selection.
- regWrite_E  in  1  instruction writes rd.
- rd_E  in  REG_ADDR_WIDTH  destination register.
- flush_M  in  1  capture a bubble instead of the execute slot.
- stall_M  out  1  to hazard unit; when high, freeze PC, IF, ID and EX.
- mem_req  out  1  data-memory request.
- mem_we  out  1  request is a write.
- mem_addr  out  DATA_WIDTH  word-aligned address, equal to {addr[31:2],2'b00}.
- mem_wdata  out  DATA_WIDTH  lane-replicated store data.
- mem_wstrb  out  4  byte enables.
- mem_rdata  in  DATA_WIDTH  read data; valid only in the cycle mem_ack is high.
- mem_ack  in  1  access complete.
- valid_W, regWrite_W  out  1 each  writeback qualifiers.
- rd_W  out  REG_ADDR_WIDTH  writeback register index.
- result_W  out  DATA_WIDTH  writeback data.
- misalign_W  out  1  one-cycle pulse flagging a misaligned access that was dropped.

## Operation
- **M register** holds valid, addr, wdata, rd, read, write, regWrite and funct3. It loads from the execute-stage inputs on the clock edge when stall_M=0. If flush_M=1 on that edge, it loads a bubble (m_valid=0, all other fields don't-care). While stall_M=1 the M register holds, and flush_M is ignored.
- **Memory op**: mop = m_valid & (read | write).
- **Misaligned**:
  - Halfword access (funct3[1:0]=01) is misaligned when addr[0]=1.
  - Word access (funct3[1:0]=10) is misaligned when addr[1:0]≠00.
  - A misaligned op issues no mem_req. It completes in one cycle with regWrite_W=0, result_W=0 and misalign_W=1.
- **FSM states**: IDLE and BUSY.
  - IDLE, mop, aligned: drive mem_req=1. If mem_ack=1 in the same cycle, complete and stay in IDLE. Otherwise go to BUSY.
  - BUSY: hold mem_req=1 with addr, we, wdata and wstrb stable. When mem_ack=1, complete and return to IDLE.
  - mem_req must never deassert before mem_ack.
- **stall_M** = mop & aligned & !mem_ack. It is combinational and valid in both IDLE and BUSY.
- **Non-memory op**: passes to W on the next edge with result_W=ALUout, and never stalls.
- **Bubble**: loads valid_W=0 and regWrite_W=0 into W.
- **Completion**: the W register loads on the same edge on which stall_M is low.
- **Store lanes**:
  - SB (000): wdata={4{b}}, wstrb=0001<<addr[1:0].
  - SH (001): wdata={2{h}}, wstrb=0011<<addr[1:0].
  - SW (010): wdata=data, wstrb=1111.
- **Loads**:
  - For byte loads, take the byte at lane addr[1:0]; for halfword loads, the halfword at lane addr[1].
  - LB (000) and LH (001) sign-extend.
  - LW (010) uses the full word.
  - LBU (100) and LHU (101) zero-extend.
- **Stores**: complete with regWrite_W=0.
- **Read data path**: mem_rdata is consumed only in the ack cycle. mem_ack received in IDLE with no mop is ignored.
- **Reset**: the reset value of every output is zero. The FSM goes to IDLE, the M register is cleared to a bubble, and mem_req drops on the next edge.
  - Reset taken during BUSY abandons the access.
  - The memory model must tolerate a dropped request.

## Timing
- **Latency, no wait states**: an instruction captured into M at edge N appears in W at edge N+1. This holds for non-memory ops, for loads and stores acked in the same cycle, and for misaligned ops.
- **Latency with wait states**: with ack k cycles after the first request cycle, W loads at edge N+1+k. stall_M is high for exactly k cycles.
- **W outputs**: registered. valid_W is high for exactly one cycle per instruction. misalign_W is high only in the cycle its instruction sits in W.
- **Memory-port outputs**: mem_req, mem_addr, mem_we, mem_wdata and mem_wstrb are combinational from the M register and FSM state.
- **Back-to-back accesses**: an ack on edge N lets the next memory op be requested in cycle N+1, with no dead cycle.

## Test plan
- **Store then load**: SW 0xDEADBEEF to 0x100 (ack same cycle), then LW 0x100. Required: mem_wstrb=1111, stall_M never high, and result_W=0xDEADBEEF one cycle after the load enters M.
- **Byte and halfword lanes**: memory word 0x80FF7F01.
  - LB at 0x103 gives 0xFFFFFF80. LBU at 0x103 gives 0x00000080.
  - LH at 0x102 gives 0xFFFF80FF. LHU at 0x100 gives 0x00007F01.
  - SB 0xAB to 0x101 drives wstrb=0010 and wdata=0xABABABAB.
- **Wait states**: ack delayed 3 cycles on LW. Required: stall_M high for exactly 3 cycles, mem_req and mem_addr stable throughout, a single valid_W pulse, and upstream inputs not captured during the stall.
- **Misaligned**: LW to 0x102 and SH to 0x101. Required: mem_req never asserted, misalign_W=1, regWrite_W=0, no stall.
- **Flush and stall interaction**:
  - flush_M with a load in execute gives valid_W=0 and no mem_req.
  - flush_M during a stall is ignored, and the stalled access completes normally.
- **Reset mid-access**: rst_n low while in BUSY. Required: on the next edge mem_req=0, stall_M=0, all W outputs 0, FSM in IDLE, and a late mem_ack produces no valid_W.
